// File: rtl/cpu_clk_pkg.sv
// Shared encodings for the CPU clock controller: FSM states and mode-switch values.
package cpu_clk_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        STEP_WAIT = 3'd1,
        SLOW      = 3'd2,
        FAST      = 3'd3,
        TRAPPED   = 3'd4
    } cpu_state_e;

    localparam logic [1:0] MODE_HALT = 2'b00;
    localparam logic [1:0] MODE_STEP = 2'b01;
    localparam logic [1:0] MODE_SLOW = 2'b10;
    localparam logic [1:0] MODE_FAST = 2'b11;

    // Running state requested by the mode switches.
    function automatic cpu_state_e mode_to_state(input logic [1:0] mode);
        cpu_state_e st;
        case (mode)
            MODE_STEP: st = STEP_WAIT;
            MODE_SLOW: st = SLOW;
            MODE_FAST: st = FAST;
            default:   st = IDLE;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/step_debouncer.sv
// Push-button conditioner: two-flop synchroniser, stability counter, and a
// one-cycle pulse on each accepted rising edge of the button level.
module step_debouncer #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk_50MHz,
    input  logic reset,
    input  logic btn_raw,
    output logic btn_rise
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rise_q, rise_d;

    // Accept a new level only after it has differed from the stable level for
    // DEBOUNCE_CYCLES consecutive cycles; any return to the old level restarts.
    always_comb begin
        sync1_d  = btn_raw;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        cnt_d    = '0;
        rise_d   = 1'b0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = sync2_q;
                rise_d   = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Register the synchroniser, stability state and edge pulse.
    always_ff @(posedge clk_50MHz) begin
        if (reset) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
            rise_q   <= 1'b0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            rise_q   <= rise_d;
        end
    end

    assign btn_rise = rise_q;

endmodule

// File: rtl/cpu_clock_controller.sv
// CPU clock-enable sequencer: halt / single-step / slow / fast modes, halt trap,
// registered one-cycle enable pulses and a count of pulses issued.
module cpu_clock_controller
    import cpu_clk_pkg::*;
#(
    parameter int SLOW_DIV        = 50_000_000,
    parameter int DIV_WIDTH       = 26,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int TICK_WIDTH      = 16
) (
    input  logic                  clk_50MHz,
    input  logic                  reset,
    input  logic [1:0]            mode,
    input  logic                  step_btn,
    input  logic                  halt_req,
    output logic                  cpu_clk_en,
    output logic [2:0]            state,
    output logic [TICK_WIDTH-1:0] tick_count
);

    localparam logic [DIV_WIDTH-1:0] DIV_LAST = DIV_WIDTH'(SLOW_DIV - 1);

    cpu_state_e            state_q, state_d;
    logic [DIV_WIDTH-1:0]  div_q, div_d;
    logic                  cpu_clk_en_q, cpu_clk_en_d;
    logic [TICK_WIDTH-1:0] tick_q, tick_d;
    logic                  btn_rise;

    step_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_step_debouncer (
        .clk_50MHz(clk_50MHz),
        .reset    (reset),
        .btn_raw  (step_btn),
        .btn_rise (btn_rise)
    );

    // Next state: halt traps from running states; TRAPPED waits for the halt mode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:                  state_d = mode_to_state(mode);
            STEP_WAIT, SLOW, FAST: state_d = halt_req ? TRAPPED : mode_to_state(mode);
            TRAPPED:               state_d = (mode == MODE_HALT) ? IDLE : TRAPPED;
            default:               state_d = IDLE;
        endcase
    end

    // Divide counter restarts on every state change and only runs in SLOW.
    always_comb begin
        div_d = '0;
        if (state_d == state_q && state_q == SLOW && div_q != DIV_LAST) begin
            div_d = div_q + 1'b1;
        end
    end

    // Enable pulse: suppressed on any state change, so FAST starts one edge late.
    always_comb begin
        cpu_clk_en_d = 1'b0;
        if (state_d == state_q) begin
            case (state_q)
                STEP_WAIT: cpu_clk_en_d = btn_rise;
                SLOW:      cpu_clk_en_d = (div_q == DIV_LAST);
                FAST:      cpu_clk_en_d = 1'b1;
                default:   cpu_clk_en_d = 1'b0;
            endcase
        end
    end

    // Count every cycle in which the enable is high; wraps naturally.
    always_comb begin
        tick_d = tick_q + {{(TICK_WIDTH-1){1'b0}}, cpu_clk_en_q};
    end

    // State, divider, enable and tick registers with synchronous reset.
    always_ff @(posedge clk_50MHz) begin
        if (reset) begin
            state_q      <= IDLE;
            div_q        <= '0;
            cpu_clk_en_q <= 1'b0;
            tick_q       <= '0;
        end else begin
            state_q      <= state_d;
            div_q        <= div_d;
            cpu_clk_en_q <= cpu_clk_en_d;
            tick_q       <= tick_d;
        end
    end

    assign cpu_clk_en = cpu_clk_en_q;
    assign state      = state_q;
    assign tick_count = tick_q;

endmodule

// File: tb/tb_cpu_clock_controller.sv
// Directed bench for cpu_clock_controller with a per-cycle expectation queue.
module tb_cpu_clock_controller;

    logic       clk_50MHz = 1'b0;
    logic       reset     = 1'b1;
    logic [1:0] mode      = 2'b00;
    logic       step_btn  = 1'b0;
    logic       halt_req  = 1'b0;
    logic       cpu_clk_en;
    logic [2:0] state;
    logic [3:0] tick_count;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string      tag;
        logic       en;
        logic [2:0] st;
        logic [3:0] tk;
    } exp_t;

    exp_t sb_q[$];

    // Expected tick count is built from the bench's own expected pulses.
    logic [3:0] model_tick = 4'd0;
    logic       model_prev_en = 1'b0;

    cpu_clock_controller #(
        .SLOW_DIV       (10),
        .DIV_WIDTH      (4),
        .DEBOUNCE_CYCLES(4),
        .TICK_WIDTH     (4)
    ) dut (
        .clk_50MHz (clk_50MHz),
        .reset     (reset),
        .mode      (mode),
        .step_btn  (step_btn),
        .halt_req  (halt_req),
        .cpu_clk_en(cpu_clk_en),
        .state     (state),
        .tick_count(tick_count)
    );

    always #5 clk_50MHz = ~clk_50MHz;

    // One clock edge: push the expectation, advance, then pop and compare.
    task automatic cyc(input string tag, input logic exp_en, input logic [2:0] exp_st);
        exp_t e;
        exp_t got;
        e.tag = tag;
        e.en  = exp_en;
        e.st  = exp_st;
        e.tk  = reset ? 4'd0 : (model_tick + {3'b000, model_prev_en});
        model_tick    = e.tk;
        model_prev_en = reset ? 1'b0 : exp_en;
        sb_q.push_back(e);
        @(posedge clk_50MHz);
        #1;
        got = sb_q.pop_front();
        checks++;
        assert (cpu_clk_en === got.en) else begin
            failures++;
            $display("FAIL %s en: got %0b want %0b", got.tag, cpu_clk_en, got.en);
            $error("%s cpu_clk_en got %0b want %0b", got.tag, cpu_clk_en, got.en);
        end
        checks++;
        assert (state === got.st) else begin
            failures++;
            $display("FAIL %s state: got %0d want %0d", got.tag, state, got.st);
            $error("%s state got %0d want %0d", got.tag, state, got.st);
        end
        checks++;
        assert (tick_count === got.tk) else begin
            failures++;
            $display("FAIL %s tick: got %0d want %0d", got.tag, tick_count, got.tk);
            $error("%s tick_count got %0d want %0d", got.tag, tick_count, got.tk);
        end
    endtask

    task automatic cycn(input string tag, input int n, input logic exp_en, input logic [2:0] exp_st);
        for (int i = 0; i < n; i++) cyc(tag, exp_en, exp_st);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc("reset", 1'b0, 3'd0);
        reset = 1'b0;
    endtask

    // Explicit tick value check for the boundaries called out in the plan.
    task automatic check_tick(input string tag, input logic [3:0] want);
        checks++;
        assert (tick_count === want) else begin
            failures++;
            $display("FAIL %s tick: got %0d want %0d", tag, tick_count, want);
            $error("%s tick_count got %0d want %0d", tag, tick_count, want);
        end
    endtask

    initial begin
        // Reset for three cycles.
        cycn("reset3", 3, 1'b0, 3'd0);
        reset = 1'b0;

        // Slow run: pulses 10, 20, 30 cycles after entry.
        mode = 2'b10;
        cyc("slow_entry", 1'b0, 3'd2);
        cycn("slow_wait", 9, 1'b0, 3'd2);
        cyc("slow_p1", 1'b1, 3'd2);
        cycn("slow_wait", 9, 1'b0, 3'd2);
        cyc("slow_p2", 1'b1, 3'd2);
        cycn("slow_wait", 9, 1'b0, 3'd2);
        cyc("slow_p3", 1'b1, 3'd2);
        cycn("slow_tail", 5, 1'b0, 3'd2);
        check_tick("slow_total", 4'd3);

        // Fast run: 19 pulses, tick wraps to 3; halt mode stops it next edge.
        do_reset();
        mode = 2'b11;
        cyc("fast_entry", 1'b0, 3'd3);
        cycn("fast_run", 19, 1'b1, 3'd3);
        mode = 2'b00;
        cyc("fast_stop", 1'b0, 3'd0);
        check_tick("fast_wrap", 4'd3);
        cyc("idle", 1'b0, 3'd0);

        // Press completed outside STEP_WAIT is discarded.
        do_reset();
        step_btn = 1'b1;
        cycn("idle_press", 8, 1'b0, 3'd0);
        mode = 2'b01;
        cyc("step_entry", 1'b0, 3'd1);
        cycn("no_stale", 4, 1'b0, 3'd1);
        step_btn = 1'b0;
        cycn("release", 8, 1'b0, 3'd1);

        // Bounce 1,0,1 then held: exactly one pulse, 7 cycles after stable high.
        step_btn = 1'b1;
        cyc("bounce1", 1'b0, 3'd1);
        step_btn = 1'b0;
        cyc("bounce0", 1'b0, 3'd1);
        step_btn = 1'b1;
        cycn("debounce", 6, 1'b0, 3'd1);
        cyc("step_pulse", 1'b1, 3'd1);
        cycn("held", 23, 1'b0, 3'd1);
        check_tick("step_count", 4'd1);
        step_btn = 1'b0;
        cycn("release", 8, 1'b0, 3'd1);

        // Halt at the edge a slow pulse is due: trapped, no pulse.
        do_reset();
        mode = 2'b10;
        cyc("slow_entry", 1'b0, 3'd2);
        cycn("slow_wait", 9, 1'b0, 3'd2);
        halt_req = 1'b1;
        cyc("halt_trap", 1'b0, 3'd4);
        halt_req = 1'b0;
        mode = 2'b11;
        cycn("trap_hold", 2, 1'b0, 3'd4);
        mode = 2'b00;
        cyc("trap_exit", 1'b0, 3'd0);
        // Halt is ignored in IDLE but traps from STEP_WAIT.
        halt_req = 1'b1;
        cyc("idle_halt", 1'b0, 3'd0);
        mode = 2'b01;
        cyc("idle_halt_step", 1'b0, 3'd1);
        cyc("step_halt", 1'b0, 3'd4);
        halt_req = 1'b0;
        mode = 2'b00;
        cyc("trap_exit2", 1'b0, 3'd0);
        check_tick("halt_count", 4'd0);

        // Reset in the middle of fast run, then resume.
        do_reset();
        mode = 2'b11;
        cyc("fast_entry", 1'b0, 3'd3);
        cycn("fast_run", 5, 1'b1, 3'd3);
        reset = 1'b1;
        cyc("mid_reset", 1'b0, 3'd0);
        reset = 1'b0;
        cyc("fast_reentry", 1'b0, 3'd3);
        cycn("fast_resume", 3, 1'b1, 3'd3);

        // Mode change restarts the divide counter.
        mode = 2'b10;
        cyc("slow_entry", 1'b0, 3'd2);
        cycn("slow_part", 6, 1'b0, 3'd2);
        mode = 2'b11;
        cyc("fast_blip", 1'b0, 3'd3);
        mode = 2'b10;
        cyc("slow_reentry", 1'b0, 3'd2);
        cycn("slow_restart", 9, 1'b0, 3'd2);
        cyc("slow_p_after", 1'b1, 3'd2);
        cycn("slow_tail", 2, 1'b0, 3'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cpu_clock_controller.md
Name: cpu_clock_controller

Overview:
Sequences the processor's clock enable from the 50 MHz board clock.
- Four modes, selected from DE1 switches: halt, single-step (debounced push-button), slow run (divided tick, default 1 Hz) and full-speed run.
- Replaces free-running use of the standalone clock divider; the divide counter is internal and is cleared on every mode change.
- Traps on a CPU halt request.
- Outputs a one-cycle clock-enable pulse, a state indication and a retired-tick counter.

Parameters:
- SLOW_DIV, 50_000_000, clk_50MHz cycles per slow tick (1 Hz); minimum 2.
- DIV_WIDTH, 26, width of the divide counter; must satisfy 2^DIV_WIDTH >= SLOW_DIV.
- DEBOUNCE_CYCLES, 1_000_000, cycles step_btn must be stable before it is accepted (20 ms); minimum 1.
- TICK_WIDTH, 16, width of tick_count.

Ports:
- clk_50MHz  in  1  board clock; the only clock.
- reset  in  1  synchronous, active-high.
- mode  in  2  00 halt, 01 step, 10 slow, 11 fast; treated as synchronous to clk_50MHz.
- step_btn  in  1  raw push-button, active-high, asynchronous.
- halt_req  in  1  CPU halt indication, synchronous.
- cpu_clk_en  out  1  registered; one-cycle-wide enable for CPU registers.
- state  out  3  current FSM state encoding.
- tick_count  out  TICK_WIDTH  number of cpu_clk_en pulses issued.

Behaviour:
- Reset: applied at a clock edge with reset=1. Afterwards state=IDLE, cpu_clk_en=0, tick_count=0, divide counter=0, debouncer cleared (stable level 0). Reset overrides all other inputs and may be asserted mid-operation.
- FSM states: IDLE=0, STEP_WAIT=1, SLOW=2, FAST=3, TRAPPED=4.
- Mode transitions: from IDLE, STEP_WAIT, SLOW or FAST, the next state is taken from mode each edge: 00→IDLE, 01→STEP_WAIT, 10→SLOW, 11→FAST.
- Halt trap: halt_req=1 at an edge in STEP_WAIT, SLOW or FAST forces TRAPPED.
  - halt_req has priority over mode and over a pulse due at that same edge; cpu_clk_en=0 after that edge.
  - halt_req is ignored in IDLE.
- TRAPPED: exits to IDLE only when mode=00; otherwise it stays TRAPPED. halt_req has no further effect there.
- Divide counter: cleared at any edge where the state changes.
  - In SLOW it counts 0..SLOW_DIV-1 and wraps to 0. cpu_clk_en=1 for the cycle following the edge at which the counter wraps.
  - First pulse comes SLOW_DIV cycles after entering SLOW.
  - Counter holds 0 in all other states.
- FAST: cpu_clk_en=1 in every cycle after the first edge at which state is FAST. Entering FAST at edge N gives the first pulse after edge N+1.
- STEP_WAIT:
  - One cpu_clk_en pulse per rising edge of the debounced button.
  - Holding the button gives exactly one pulse.
  - A press completed while not in STEP_WAIT is discarded. The debouncer runs in every state; only the edge output is gated.
- Debouncer:
  - 2-flop synchroniser, then a stability counter.
  - The accepted level updates only after the synchronised input differs from it for DEBOUNCE_CYCLES consecutive cycles.
  - Any bounce restarts the count.
  - Rising-edge pulse lasts one cycle.
  - Latency from a clean press to cpu_clk_en = 2 + DEBOUNCE_CYCLES + 1 cycles.
- cpu_clk_en is 0 in IDLE and TRAPPED, and 0 in the cycle after any state change, except entry into FAST as defined above.
- tick_count: increments by 1 in every cycle where cpu_clk_en=1. Wraps from all-ones to 0. Cleared only by reset.

Decomposition:
- Shared package cpu_clk_pkg:
  - state encodings IDLE/STEP_WAIT/SLOW/FAST/TRAPPED;
  - mode constants MODE_HALT=2'b00, MODE_STEP=2'b01, MODE_SLOW=2'b10, MODE_FAST=2'b11.
- One sub-module: step_debouncer.
  - Ports clk_50MHz, reset, btn_raw, btn_rise.
  - Parameter DEBOUNCE_CYCLES.
- FSM, divide counter and tick counter stay in the top level.

Test Plan:
All runs use SLOW_DIV=10, DEBOUNCE_CYCLES=4, TICK_WIDTH=4 to keep simulation short; the full 1 Hz run is not simulated.
1. Reset 3 cycles, mode=10 → state=2; pulses after cycles 10, 20, 30 following entry; tick_count=3 after 35 cycles; no other pulses.
2. mode=11 for 20 cycles → 19 consecutive pulses, tick_count=19 mod 16=3 (wrap verified). Then mode=00 → cpu_clk_en=0 from next cycle, state=0.
3. mode=01, step_btn bounce 1,0,1 each 1 cycle, then held high 30 cycles → exactly one pulse, 7 cycles after stable high; tick_count=1.
4. mode=10, halt_req=1 at the edge where the 10th-cycle pulse is due → no pulse, state=4. Then mode=11 → stays 4; mode=00 → state=0 next edge.
5. mode=11 running, reset=1 for 1 cycle mid-stream → cpu_clk_en=0, tick_count=0, state=0. With reset released and mode still 11 → FAST, pulses resume after 2 edges.
6. mode=10 for 7 cycles, then mode=11 for 1 cycle, then mode=10 → divide counter restarts; next slow pulse arrives 10 cycles after re-entry, not 3.
